gauss_seq_ctrl: RTL and testbench

- Sequencer for the 5x5 Gaussian line-buffer datapath.
- Turns a pixel-valid / start-of-frame stream into the datapath's col, buff_en and shift_en controls.
- Tracks line fill and asserts the filter enable only where a full 5x5 window exists.
- Owns the 40-bit coefficient register and applies CPU coefficient updates only at frame boundaries.

---
 rtl/gauss_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_gauss_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_seq_ctrl.sv
// Control sequencer for the 5x5 Gaussian line-buffer datapath: column/shift
// generation, line-fill tracking, window enable and frame-synchronous coefficients.
// Optional forced line close on mid-line idle: define GAUSS_SEQ_TIMEOUT_EN.
module gauss_seq_ctrl #(
   parameter int H_ACT      = 640,
   parameter int COL_W      = 13,
   parameter int FILL_LINES = 5,
   parameter int TIMEOUT    = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_valid,
   input  logic             sof,
   input  logic             coef_wr,
   input  logic [39:0]      coef_in,
   output logic [COL_W-1:0] col,
   output logic             buff_en,
   output logic             shift_en,
   output logic             en_gauss5x5,
   output logic [39:0]      gauss_coef,
   output logic             coef_pend,
   output logic             line_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam logic [39:0]      COEF_DEF  = 40'h0909_0A0A_0A;
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_ACT - 1);
   localparam logic [COL_W-1:0] COL_FIRST = (H_ACT > 1) ? COL_W'(1) : '0;
   localparam logic [COL_W-1:0] COL_LO    = COL_W'(2);
   localparam logic [COL_W-1:0] COL_HI    = COL_W'(H_ACT - 3);
   localparam int               LC_W      = $clog2(FILL_LINES + 1);
   localparam logic [LC_W-1:0]  LC_MAX    = LC_W'(FILL_LINES);
   localparam logic [LC_W-1:0]  LC_PRE    = LC_W'(FILL_LINES - 1);

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [LC_W-1:0] line_cnt;
   logic [39:0]     coef_shadow;
   logic            sof_hit;
   logic            accept;
   logic            line_end;
   logic            force_close;

   assign sof_hit  = sof & pix_valid;
   assign accept   = pix_valid & ((state != IDLE) | sof);
   assign buff_en  = accept;
   // the sof pixel is column 0 of a new line, so it never closes the old one
   assign line_end = accept & ~sof_hit & (col == COL_LAST);

`ifdef GAUSS_SEQ_TIMEOUT_EN
   localparam int              IC_W     = $clog2(TIMEOUT + 1);
   localparam logic [IC_W-1:0] IC_LAST  = IC_W'(TIMEOUT - 1);

   logic [IC_W-1:0] idle_cnt;
   logic            idle;
   logic            line_err_q;

   assign idle        = (state != IDLE) & ~pix_valid & (col != '0);
   assign force_close = idle & (idle_cnt == IC_LAST);
   assign line_err    = line_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt   <= '0;
         line_err_q <= 1'b0;
      end else begin
         if (!idle || force_close)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + IC_W'(1);
         if (force_close)
            line_err_q <= 1'b1;
      end
   end
`else
   assign force_close = 1'b0;
   assign line_err    = 1'b0;
`endif

   // RUN is entered on the same edge that line_cnt reaches FILL_LINES
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sof_hit) state_nxt = FILL;
         FILL:    if ((shift_en && line_cnt == LC_PRE) || line_cnt == LC_MAX)
                     state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      if (sof_hit)
         state_nxt = FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         col         <= '0;
         shift_en    <= 1'b0;
         en_gauss5x5 <= 1'b0;
         line_cnt    <= '0;
         gauss_coef  <= COEF_DEF;
         coef_shadow <= COEF_DEF;
         coef_pend   <= 1'b0;
      end else begin
         state       <= state_nxt;
         shift_en    <= line_end | force_close;
         en_gauss5x5 <= (state == RUN) & pix_valid & ~sof_hit &
                        (col >= COL_LO) & (col <= COL_HI);

         if (sof_hit)
            col <= COL_FIRST;
         else if (force_close)
            col <= '0;
         else if (accept)
            col <= (col == COL_LAST) ? '0 : col + COL_W'(1);

         if (sof_hit)
            line_cnt <= '0;
         else if (shift_en && line_cnt != LC_MAX)
            line_cnt <= line_cnt + LC_W'(1);

         // a write coinciding with sof lands in the shadow for the next frame
         if (sof_hit && coef_pend)
            gauss_coef <= coef_shadow;
         if (coef_wr) begin
            coef_shadow <= coef_in;
            coef_pend   <= 1'b1;
         end else if (sof_hit) begin
            coef_pend   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gauss_seq_ctrl.sv
// Directed bench for gauss_seq_ctrl with H_ACT=8 and TIMEOUT=16; the forced
// line-close checks follow GAUSS_SEQ_TIMEOUT_EN.
module tb_gauss_seq_ctrl;

   localparam int H_ACT = 8;
   localparam int COL_W = 13;
   localparam logic [39:0] COEF_DEF = 40'h0909_0A0A_0A;

   logic             clk;
   logic             rst_n;
   logic             pix_valid;
   logic             sof;
   logic             coef_wr;
   logic [39:0]      coef_in;
   logic [COL_W-1:0] col;
   logic             buff_en;
   logic             shift_en;
   logic             en_gauss5x5;
   logic [39:0]      gauss_coef;
   logic             coef_pend;
   logic             line_err;

   int n_tests;
   int n_fail;
   int n_shift;
   int n_en;
   int n_en_gap;
   int n_buff;
   int n_hold_err;
   logic [COL_W-1:0] col_pre;
   logic [7:0]       en_hist;

   gauss_seq_ctrl #(
      .H_ACT      (H_ACT),
      .COL_W      (COL_W),
      .FILL_LINES (5),
      .TIMEOUT    (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .sof         (sof),
      .coef_wr     (coef_wr),
      .coef_in     (coef_in),
      .col         (col),
      .buff_en     (buff_en),
      .shift_en    (shift_en),
      .en_gauss5x5 (en_gauss5x5),
      .gauss_coef  (gauss_coef),
      .coef_pend   (coef_pend),
      .line_err    (line_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      n_shift = 0; n_en = 0; n_en_gap = 0; n_buff = 0; n_hold_err = 0; en_hist = '0;
   endtask

   // one clock: drive inputs, sample buff_en and col before the edge, registered outputs after
   task automatic cyc(input logic pv, input logic s);
      pix_valid = pv;
      sof       = s;
      #1;
      col_pre = col;
      if (buff_en) n_buff++;
      @(posedge clk);
      #1;
      if (shift_en) n_shift++;
      if (en_gauss5x5) n_en++;
      if (en_gauss5x5 && !pv) n_en_gap++;
      if (pv) en_hist[col_pre[2:0]] = en_gauss5x5;
      if (!pv && col != col_pre) n_hold_err++;
      pix_valid = 1'b0;
      sof       = 1'b0;
      coef_wr   = 1'b0;
   endtask

   task automatic full_line();
      for (int i = 0; i < H_ACT; i++) cyc(1'b1, 1'b0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; coef_wr = 1'b0; coef_in = '0;
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      check("rst_col", 64'(col), 64'd0);
      check("rst_shift", 64'(shift_en), 64'd0);
      check("rst_en", 64'(en_gauss5x5), 64'd0);
      check("rst_coef", 64'(gauss_coef), 64'(COEF_DEF));
      check("rst_pend", 64'(coef_pend), 64'd0);
      check("rst_lerr", 64'(line_err), 64'd0);
      rst_n = 1'b1;

      // first line starting at sof
      for (int i = 0; i < H_ACT; i++) begin
         cyc(1'b1, i == 0);
         check("l1_col", 64'(col_pre), 64'(i));
      end
      check("l1_wrap", 64'(col), 64'd0);
      check("l1_shift", 64'(shift_en), 64'd1);
      check("l1_nshift", 64'(n_shift), 64'd1);
      check("l1_buff", 64'(n_buff), 64'd8);
      cyc(1'b0, 1'b0);
      check("l1_shift_off", 64'(shift_en), 64'd0);

      // lines 2..5 keep the window disabled
      for (int l = 0; l < 4; l++) full_line();
      check("fill_en", 64'(n_en), 64'd0);
      check("fill_nshift", 64'(n_shift), 64'd5);

      // line 6: window valid for cols 2..5, coefficient writes stay pending
      clr_stats();
      for (int i = 0; i < H_ACT; i++) begin
         if (i == 1) begin coef_wr = 1'b1; coef_in = 40'h11_1111_1111; end
         if (i == 3) begin coef_wr = 1'b1; coef_in = 40'h01_0203_0405; end
         cyc(1'b1, 1'b0);
         if (i == 3) begin
            check("cw_pend", 64'(coef_pend), 64'd1);
            check("cw_hold", 64'(gauss_coef), 64'(COEF_DEF));
         end
      end
      check("l6_hist", 64'(en_hist), 64'h3C);
      check("l6_nen", 64'(n_en), 64'd4);

      // line 7 with a gap after every pixel
      clr_stats();
      for (int i = 0; i < H_ACT; i++) begin
         cyc(1'b1, 1'b0);
         cyc(1'b0, 1'b0);
      end
      check("gap_hold", 64'(n_hold_err), 64'd0);
      check("gap_nshift", 64'(n_shift), 64'd1);
      check("gap_nen", 64'(n_en), 64'd4);
      check("gap_en_off", 64'(n_en_gap), 64'd0);
      check("gap_hist", 64'(en_hist), 64'h3C);

      // sof mid-line at col 4, with a coefficient write on the same cycle
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
      check("mid_col4", 64'(col), 64'd4);
      coef_wr = 1'b1; coef_in = 40'hAA_BBCC_DDEE;
      cyc(1'b1, 1'b1);
      check("mid_col1", 64'(col), 64'd1);
      check("mid_noshift", 64'(shift_en), 64'd0);
      check("sof_coef", 64'(gauss_coef), 64'h01_0203_0405);
      check("sof_wr_pend", 64'(coef_pend), 64'd1);
      clr_stats();
      for (int i = 1; i < H_ACT; i++) cyc(1'b1, 1'b0);
      for (int l = 0; l < 4; l++) full_line();
      check("refill_en", 64'(n_en), 64'd0);
      check("refill_nshift", 64'(n_shift), 64'd5);

      cyc(1'b1, 1'b1);
      check("sof2_coef", 64'(gauss_coef), 64'hAA_BBCC_DDEE);
      check("sof2_pend", 64'(coef_pend), 64'd0);

      // stall mid-line at col 3
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("stall_col", 64'(col), 64'd3);
      clr_stats();
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 1'b0);
`ifdef GAUSS_SEQ_TIMEOUT_EN
         if (i == 14) begin
            check("to_pre_col", 64'(col), 64'd3);
            check("to_pre_shift", 64'(shift_en), 64'd0);
         end
         if (i == 15) begin
            check("to_shift", 64'(shift_en), 64'd1);
            check("to_col", 64'(col), 64'd0);
            check("to_lerr", 64'(line_err), 64'd1);
         end
`endif
      end
`ifdef GAUSS_SEQ_TIMEOUT_EN
      check("to_nshift", 64'(n_shift), 64'd1);
      check("to_lerr_sticky", 64'(line_err), 64'd1);
`else
      check("wait_nshift", 64'(n_shift), 64'd0);
      check("wait_col", 64'(col), 64'd3);
      check("wait_lerr", 64'(line_err), 64'd0);
`endif

      // asynchronous reset mid-frame with a pending coefficient
      coef_wr = 1'b1; coef_in = 40'h55_6677_8899;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("pre_rst_pend", 64'(coef_pend), 64'd1);
      pix_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_col", 64'(col), 64'd0);
      check("arst_pend", 64'(coef_pend), 64'd0);
      check("arst_coef", 64'(gauss_coef), 64'(COEF_DEF));
      check("arst_lerr", 64'(line_err), 64'd0);
      check("arst_shift", 64'(shift_en), 64'd0);
      pix_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      clr_stats();
      cyc(1'b1, 1'b0);
      check("idle_nobuff", 64'(n_buff), 64'd0);
      check("idle_col", 64'(col), 64'd0);
      cyc(1'b1, 1'b1);
      check("restart_buff", 64'(n_buff), 64'd1);
      check("restart_col", 64'(col), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
